arithmetic_unit: RTL and testbench

ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

---
 rtl/arithmetic_unit.sv | 50 +++++
 tb/tb_arithmetic_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/arithmetic_unit.sv
// arithmetic_unit: registered signed add/sub/mul/negate with overflow flag, one-cycle latency.
// Define ARITH_UNIT_SATURATE_EN to clamp overflowing results instead of wrapping.
module arithmetic_unit #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic        [1:0]       sel,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] Q,
    output logic                    overflow,
    output logic                    out_valid
);
    localparam int PW = 2 * WIDTH;
    logic signed [PW-1:0]    a_x, b_x, exact;
    logic [PW-WIDTH:0]       top;
    logic                    ov;
    logic signed [WIDTH-1:0] q_next;
    assign a_x = PW'(A);
    assign b_x = PW'(B);
    // 2*WIDTH bits hold every exact sum, difference, product and negation
    always_comb
        exact = sel == 2'b00 ? a_x + b_x :
                sel == 2'b01 ? a_x - b_x :
                sel == 2'b10 ? a_x * b_x : -a_x;
    // in range iff every bit above the result's sign bit matches it
    assign top = exact[PW-1:WIDTH-1];
    assign ov  = !(&top || ~|top);
`ifdef ARITH_UNIT_SATURATE_EN
    always_comb
        q_next = !ov ? exact[WIDTH-1:0] :
                 exact[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign q_next = exact[WIDTH-1:0];
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            Q         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Q        <= q_next;
                overflow <= ov;
            end
        end
endmodule

// File: tb/tb_arithmetic_unit.sv
// tb_arithmetic_unit: directed vectors, reset/hold checks and an exhaustive sweep.
module tb_arithmetic_unit;
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic signed [3:0] A = '0, B = '0;
    logic        [1:0] sel = '0;
    logic              in_valid = 1'b0;
    logic signed [3:0] Q;
    logic              overflow, out_valid;
    int n_cmp = 0, n_bad = 0;

    arithmetic_unit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel),
        .in_valid(in_valid), .Q(Q), .overflow(overflow), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {out_valid, overflow, Q};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed {vld,ov,Q}=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic go(input logic signed [3:0] a, input logic signed [3:0] b,
                      input logic [1:0] s, input logic v);
        A = a; B = b; sel = s; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] model(input logic signed [3:0] a,
                                         input logic signed [3:0] b, input logic [1:0] s);
        int e;
        logic o;
        logic [3:0] q;
        e = s == 2'd0 ? int'(a) + int'(b) :
            s == 2'd1 ? int'(a) - int'(b) :
            s == 2'd2 ? int'(a) * int'(b) : -int'(a);
        o = (e > 7) || (e < -8);
        q = e[3:0];
`ifdef ARITH_UNIT_SATURATE_EN
        if (o) q = (e > 0) ? 4'b0111 : 4'b1000;
`endif
        return {1'b1, o, q};
    endfunction

`ifdef ARITH_UNIT_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    initial begin
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 6'b000000);
        #3 rst_n = 1'b1;
        go(4'sd5, 4'sd3, 2'b00, 1'b1);
        chk("add_5_3", SAT ? 6'b110111 : 6'b111000);
        go(-4'sd8, 4'sd1, 2'b01, 1'b1);
        chk("sub_m8_1", SAT ? 6'b111000 : 6'b110111);
        go(4'sd3, 4'sd5, 2'b01, 1'b1);
        chk("sub_3_5", 6'b101110);
        go(4'sd3, 4'sd3, 2'b10, 1'b1);
        chk("mul_3_3", SAT ? 6'b110111 : 6'b111001);
        go(-4'sd2, 4'sd4, 2'b10, 1'b1);
        chk("mul_m2_4", 6'b101000);
        go(-4'sd8, 4'sd0, 2'b11, 1'b1);
        chk("neg_m8", SAT ? 6'b110111 : 6'b111000);
        go(4'sd5, 4'sd0, 2'b11, 1'b1);
        chk("neg_5", 6'b101011);
        go(-4'sd8, -4'sd8, 2'b00, 1'b1);
        chk("add_m8_m8", SAT ? 6'b111000 : 6'b110000);
        go(-4'sd8, -4'sd8, 2'b01, 1'b1);
        chk("sub_m8_m8", 6'b100000);
        go(-4'sd8, -4'sd8, 2'b10, 1'b1);
        chk("mul_m8_m8", SAT ? 6'b110111 : 6'b110000);
        go(4'sd1, 4'sd1, 2'b00, 1'b0);
        chk("hold_gap", SAT ? 6'b010111 : 6'b010000);
        go(4'sd3, 4'sd5, 2'b01, 1'b1);
        chk("resume", 6'b101110);
        A = 4'sd1; B = 4'sd1; sel = 2'b00;
        #2 rst_n = 1'b0;
        #1 chk("reset_mid", 6'b000000);
        @(posedge clk); #1;
        chk("reset_held", 6'b000000);
        rst_n = 1'b1;
        go(4'sd2, 4'sd2, 2'b00, 1'b0);
        chk("no_stale_pulse", 6'b000000);
        go(4'sd2, 4'sd2, 2'b00, 1'b1);
        chk("first_after_reset", 6'b100100);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            v = 10'(i);
            go(v[9:6], v[5:2], v[1:0], 1'b1);
            chk($sformatf("sweep_%0d", i), model(v[9:6], v[5:2], v[1:0]));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
